// File: rtl/sha_pkg.sv
// ---------------------------------------------------------------------------
// sha_pkg
// Shared definitions for the SHA-256 blocks: the block builder FSM state
// type, block geometry constants, the padding marker byte, and the SHA-256
// initial hash values (H0) and round constants (K) used by sha256.
// No ports (package).
// ---------------------------------------------------------------------------
package sha_pkg;

    // Block builder FSM states
    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        EMIT = 2'd2,
        TAIL = 2'd3
    } state_e;

    // Geometry of a padded SHA-256 block
    localparam int BLOCK_W        = 512;
    localparam int BYTES_PER_BLK  = 64;
    localparam int LEN_FIELD_BYTE = 56;

    // First padding byte written directly after the message
    localparam logic [7:0] PAD_MARKER = 8'h80;

    // SHA-256 initial hash value
    localparam logic [31:0] SHA_H0 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // SHA-256 round constants
    localparam logic [31:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha_block_builder.sv
// ---------------------------------------------------------------------------
// sha_block_builder
// Streaming byte-level SHA-256 front end. Packs message bytes big-endian into
// 512-bit blocks and appends the standard padding (0x80 marker, zero fill,
// 64-bit message bit length). Emits complete padded blocks downstream.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_data    in   [7:0] message byte
//   in_valid   in   in_data valid
//   in_last    in   in_data is the final byte of the message
//   in_ready   out  a byte is accepted this cycle when in_valid is also high
//   blk_data   out  [BLOCK_W-1:0] padded block, byte 0 at the top bits
//   blk_valid  out  blk_data valid
//   blk_last   out  block is the final block of the message
//   blk_ready  in   downstream accepts the block
// ---------------------------------------------------------------------------
module sha_block_builder #(
    parameter int BLOCK_W = 512,
    parameter int CNT_W   = 61
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] blk_data,
    output logic               blk_valid,
    output logic               blk_last,
    input  logic               blk_ready
);

    import sha_pkg::*;

    state_e             state_q, state_d;
    logic [BLOCK_W-1:0] buf_q, buf_d;
    logic [5:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         lastPos_q, lastPos_d;
    logic               last_q, last_d;
    logic               needTail_q, needTail_d;
    logic               tailMarker_q, tailMarker_d;

    logic               inReadyInt;
    logic               blkValidInt;
    logic [6:0]         dataBytes;
    logic [63:0]        lenField;

    // Message length in bits, zero-extended into the 64-bit length field
    assign lenField  = 64'(cnt_q) << 3;

    // Number of message bytes that landed in the block holding the last byte
    assign dataBytes = {1'b0, lastPos_q} + 7'd1;

    // Next-state logic: byte packing in FILL, padding in PAD, the extra
    // length-only block in TAIL, and the output handshake in EMIT.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        lastPos_d    = lastPos_q;
        last_d       = last_q;
        needTail_d   = needTail_q;
        tailMarker_d = tailMarker_q;
        inReadyInt   = 1'b0;
        blkValidInt  = 1'b0;

        case (state_q)
            FILL: begin
                inReadyInt = 1'b1;
                if (in_valid) begin
                    for (int b = 0; b < BYTES_PER_BLK; b++) begin
                        if (idx_q == 6'(b)) begin
                            buf_d[BLOCK_W-1-8*b -: 8] = in_data;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (in_last) begin
                        lastPos_d = idx_q;
                        state_d   = PAD;
                    end else if (idx_q == 6'(BYTES_PER_BLK-1)) begin
                        last_d     = 1'b0;
                        needTail_d = 1'b0;
                        state_d    = EMIT;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end

            // Bytes past the last data byte are already zero because the
            // buffer is cleared on every return to FILL, so only the marker
            // and (if it fits) the length field need to be written here.
            PAD: begin
                if (lastPos_q == 6'(BYTES_PER_BLK-1)) begin
                    last_d       = 1'b0;
                    needTail_d   = 1'b1;
                    tailMarker_d = 1'b1;
                end else begin
                    for (int b = 0; b < BYTES_PER_BLK; b++) begin
                        if (dataBytes == 7'(b)) begin
                            buf_d[BLOCK_W-1-8*b -: 8] = PAD_MARKER;
                        end
                    end
                    if (dataBytes < 7'(LEN_FIELD_BYTE)) begin
                        buf_d[63:0] = lenField;
                        last_d      = 1'b1;
                        needTail_d  = 1'b0;
                    end else begin
                        last_d       = 1'b0;
                        needTail_d   = 1'b1;
                        tailMarker_d = 1'b0;
                    end
                end
                state_d = EMIT;
            end

            EMIT: begin
                blkValidInt = 1'b1;
                if (blk_ready) begin
                    if (needTail_q) begin
                        state_d = TAIL;
                    end else begin
                        buf_d   = '0;
                        idx_d   = '0;
                        state_d = FILL;
                        if (last_q) begin
                            cnt_d = '0;
                        end
                    end
                end
            end

            // Extra block carrying only the length (and the marker when the
            // message exactly filled the previous block).
            TAIL: begin
                buf_d = '0;
                if (tailMarker_q) begin
                    buf_d[BLOCK_W-1 -: 8] = PAD_MARKER;
                end
                buf_d[63:0] = lenField;
                last_d      = 1'b1;
                needTail_d  = 1'b0;
                state_d     = EMIT;
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State registers with synchronous reset; reset discards any partial
    // block and the running byte count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FILL;
            buf_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            lastPos_q    <= '0;
            last_q       <= 1'b0;
            needTail_q   <= 1'b0;
            tailMarker_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            lastPos_q    <= lastPos_d;
            last_q       <= last_d;
            needTail_q   <= needTail_d;
            tailMarker_q <= tailMarker_d;
        end
    end

    // Outputs are forced low while reset is held, independent of the
    // registered state.
    assign in_ready  = rst_n & inReadyInt;
    assign blk_valid = rst_n & blkValidInt;
    assign blk_last  = rst_n & blkValidInt & last_q;
    assign blk_data  = rst_n ? buf_q : '0;

endmodule

// File: tb/tb_sha_block_builder.sv
// ---------------------------------------------------------------------------
// tb_sha_block_builder
// Self-checking bench for sha_block_builder. Expected padded blocks are built
// from each message with the textbook padding rule and queued; a monitor pops
// and compares them on every output handshake. Directed steps also check
// reset outputs, latency and backpressure behaviour.
// ---------------------------------------------------------------------------
module tb_sha_block_builder;

    typedef struct {
        logic [511:0] data;
        logic         last;
    } blk_t;

    logic         clk;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready;

    int           total = 0;
    int           bad = 0;
    int           hsCount = 0;
    blk_t         expQ[$];
    logic [7:0]   msg[$];

    sha_block_builder #(.BLOCK_W(512), .CNT_W(61)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_last  (blk_last),
        .blk_ready (blk_ready)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit bit length
    task automatic pushExpected();
        logic [7:0]   p[$];
        logic [63:0]  bitLen;
        blk_t         e;
        int           nBlk;
        p = msg;
        bitLen = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bitLen[8*k +: 8]);
        nBlk = p.size() / 64;
        for (int b = 0; b < nBlk; b++) begin
            e.data = '0;
            for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = p[b*64+j];
            e.last = (b == nBlk - 1);
            expQ.push_back(e);
        end
    endtask

    // Drives one byte and waits (bounded) until it is accepted
    task automatic acceptByte(input logic [7:0] d, input logic isLast);
        int waitCyc = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = isLast;
        @(negedge clk);
        while (!in_ready && waitCyc < 300) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("in_ready_accept", 512'(in_ready), 512'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends the whole msg queue; optionally marks the final byte as last
    task automatic applyStimulus(input logic markLast, input logic pushExp);
        if (pushExp) pushExpected();
        foreach (msg[i]) acceptByte(msg[i], markLast && (i == msg.size() - 1));
    endtask

    // Waits (bounded) until all expected blocks were handshaken
    task automatic waitDrain(input string tag);
        int c = 0;
        while (expQ.size() != 0 && c < 400) begin
            @(negedge clk);
            c++;
        end
        checkOutput(tag, 512'(expQ.size()), 512'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, 512'(in_ready), 512'(0));
        checkOutput({tag, "_blk_valid"}, 512'(blk_valid), 512'(0));
        checkOutput({tag, "_blk_last"}, 512'(blk_last), 512'(0));
        checkOutput({tag, "_blk_data"}, blk_data, 512'(0));
    endtask

    // Scoreboard monitor: every output handshake pops one expected block
    always @(negedge clk) begin
        if (rst_n && blk_valid && blk_ready) begin
            blk_t e;
            hsCount++;
            total++;
            assert (expQ.size() != 0) else begin
                bad++;
                $error("[TB] FAIL unexpected_block observed=%0h expected=none", blk_data);
            end
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("blk_data", blk_data, e.data);
                checkOutput("blk_last", 512'(blk_last), 512'(e.last));
            end
        end
    end

    initial begin
        string        nist;
        logic [511:0] held;
        logic         heldLast;
        int           hs0;
        int           c;

        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b1;

        // Reset: outputs low while rst_n is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_in_ready", 512'(in_ready), 512'(1));
        checkOutput("idle_blk_valid", 512'(blk_valid), 512'(0));
        @(posedge clk);
        #1;

        // "abc": single block, valid two edges after the last byte
        msg = '{8'h61, 8'h62, 8'h63};
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        checkOutput("abc_pad_valid", 512'(blk_valid), 512'(0));
        checkOutput("abc_pad_in_ready", 512'(in_ready), 512'(0));
        @(negedge clk);
        checkOutput("abc_emit_valid", 512'(blk_valid), 512'(1));
        checkOutput("abc_word0", 512'(blk_data[511:480]), 512'(32'h61626380));
        checkOutput("abc_lenword", 512'(blk_data[31:0]), 512'(32'h00000018));
        waitDrain("abc_drain");

        // 55 bytes: marker and length share one block
        msg.delete();
        repeat (55) msg.push_back(8'h41);
        applyStimulus(1'b1, 1'b1);
        waitDrain("len55_drain");

        // 56 bytes: length spills into a second block
        msg.delete();
        repeat (56) msg.push_back(8'h41);
        applyStimulus(1'b1, 1'b1);
        waitDrain("len56_drain");

        // 64 zero bytes: full data block, then marker + length block
        msg.delete();
        repeat (64) msg.push_back(8'h00);
        applyStimulus(1'b1, 1'b1);
        waitDrain("len64_drain");

        // NIST two-block message (56 bytes)
        nist = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        msg.delete();
        for (int i = 0; i < nist.len(); i++) msg.push_back(nist[i]);
        applyStimulus(1'b1, 1'b1);
        waitDrain("nist_drain");

        // 130 bytes: two full data blocks then a padded block
        msg.delete();
        for (int i = 0; i < 130; i++) msg.push_back(8'(i * 7 + 3));
        applyStimulus(1'b1, 1'b1);
        waitDrain("len130_drain");

        // Backpressure: block held stable while blk_ready is low
        blk_ready = 1'b0;
        msg = '{8'h61, 8'h62, 8'h63};
        applyStimulus(1'b1, 1'b1);
        hs0 = hsCount;
        c = 0;
        @(negedge clk);
        while (!blk_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        held     = blk_data;
        heldLast = blk_last;
        checkOutput("bp_valid_seen", 512'(blk_valid), 512'(1));
        in_valid = 1'b1;
        in_data  = 8'h99;
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_valid_hold", 512'(blk_valid), 512'(1));
            checkOutput("bp_data_hold", blk_data, held);
            checkOutput("bp_last_hold", 512'(blk_last), 512'(heldLast));
            checkOutput("bp_in_ready", 512'(in_ready), 512'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        blk_ready = 1'b1;
        waitDrain("bp_drain");
        @(negedge clk);
        checkOutput("bp_one_handshake", 512'(hsCount - hs0), 512'(1));
        checkOutput("bp_valid_drop", 512'(blk_valid), 512'(0));
        @(posedge clk);
        #1;

        // Reset after 20 bytes discards the partial block
        msg.delete();
        repeat (20) msg.push_back(8'h55);
        applyStimulus(1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checkResetOutputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        msg = '{8'h61, 8'h62, 8'h63};
        applyStimulus(1'b1, 1'b1);
        waitDrain("after_reset_drain");

        // Back-to-back "abc","abc": count cleared between messages
        msg = '{8'h61, 8'h62, 8'h63};
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        waitDrain("b2b_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
